// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage initiator for the multiply/divide unit. Issues MDU ops, tracks
// their latency against the MDU's stall output, and serves mfhi/mflo reads.
//   state   | meaning
//   S_IDLE  | accepting requests; may be driving a one-cycle mthi/mtlo write
//   S_ISSUE | pulsing mdu_start with the registered op and operands
//   S_WAIT  | latency counter running until the result lands in HI/LO
module mdu_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 6,
  parameter int unsigned DIV_CYCLES = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  output logic        req_ready,
  output logic        stall,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_in1,
  output logic [31:0] mdu_in2,
  input  logic        mdu_stall,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        proto_err
);
  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   rs_q, rs_d;
  logic [31:0]   rt_q, rt_d;
  logic          mt_drive_q, mt_drive_d;
  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          proto_err_q, proto_err_d;

  logic req_is_long, req_is_mt, req_is_mf, op_is_div, accept;

  assign req_is_long = req_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MSUB};
  assign req_is_mt   = req_op inside {OP_MTHI, OP_MTLO};
  assign req_is_mf   = req_op inside {OP_MFHI, OP_MFLO};
  assign op_is_div   = op_q inside {OP_DIV, OP_DIVU};

  // The mthi/mtlo drive cycle blocks accepts so a following mfhi/mflo sees the new value.
  assign req_ready = ~reset & (state_q == S_IDLE) & ~mt_drive_q;
  assign accept    = req_valid & req_ready;
  assign stall     = req_valid & ~req_ready;

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign proto_err = proto_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    mt_drive_d  = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    proto_err_d = proto_err_q;
    mdu_start   = 1'b0;
    mdu_op      = 4'd0;
    mdu_in1     = 32'd0;
    mdu_in2     = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        if (mt_drive_q) begin
          mdu_op  = op_q;
          mdu_in1 = rs_q;
        end
        if (mdu_stall) proto_err_d = 1'b1;
        if (accept) begin
          if (req_is_long) begin
            op_d    = req_op;
            rs_d    = req_rs;
            rt_d    = req_rt;
            state_d = S_ISSUE;
          end else if (req_is_mt) begin
            op_d       = req_op;
            rs_d       = req_rs;
            mt_drive_d = 1'b1;
          end else if (req_is_mf) begin
            rd_valid_d = 1'b1;
            rd_data_d  = (req_op == OP_MFHI) ? mdu_hi : mdu_lo;
          end
        end
      end
      S_ISSUE: begin
        mdu_start = 1'b1;
        mdu_op    = op_q;
        mdu_in1   = rs_q;
        mdu_in2   = rt_q;
        cnt_d     = op_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
          if (!mdu_stall) proto_err_d = 1'b1;
        end else begin
          // Counter expired: hold here until the MDU also reports done.
          cnt_d = '0;
          if (!mdu_stall) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      mdu_start = 1'b0;
      mdu_op    = 4'd0;
      mdu_in1   = 32'd0;
      mdu_in2   = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 4'd0;
      rs_q        <= 32'd0;
      rt_q        <= 32'd0;
      mt_drive_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      mt_drive_q  <= mt_drive_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule
